// File: rtl/rr_arb_4ch_16bit_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_4ch_16bit_pkg
// Shared constants and types for the 4-channel round-robin arbiter and the
// downstream 4:1 data select stage.
//   WIDTH      : payload word width
//   SEL_WIDTH  : channel index width (select code of the downstream mux)
//   NUM_CH     : number of arbitrated channels (fixed at 4)
//   sel_t      : channel index / mux select code type
//   out_state_t: occupancy of the output register
// ---------------------------------------------------------------------------
package rr_arb_4ch_16bit_pkg;

  localparam int WIDTH     = 16;
  localparam int SEL_WIDTH = 2;
  localparam int NUM_CH    = 4;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Index reached by stepping 'off' positions past 'base', wrapping modulo 4.
  function automatic sel_t rr_step(sel_t base, sel_t off);
    return sel_t'(base + off);
  endfunction

endpackage

// File: rtl/rr_arb_4ch_16bit_if.sv
// ---------------------------------------------------------------------------
// rr_arb_4ch_16bit_if
// Bundles the four valid/ready source channels and the single registered
// valid/ready output of the arbiter.
//   in_valid[3:0]  : per-channel request, bit i belongs to data<i>
//   in_ready[3:0]  : per-channel accept, one-hot or zero
//   data0..data3   : channel payloads
//   out_valid      : output word valid
//   out_ready      : downstream ready
//   out_data       : granted word
//   out_sel        : index of the channel that supplied out_data
// Modports:
//   master : source/sink environment (drives requests and out_ready)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface rr_arb_4ch_16bit_if #(
  parameter int WIDTH     = 16,
  parameter int SEL_WIDTH = 2
);

  logic [3:0]           in_valid;
  logic [3:0]           in_ready;
  logic [WIDTH-1:0]     data0;
  logic [WIDTH-1:0]     data1;
  logic [WIDTH-1:0]     data2;
  logic [WIDTH-1:0]     data3;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;

  modport master (
    output in_valid,
    output data0,
    output data1,
    output data2,
    output data3,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  data0,
    input  data1,
    input  data2,
    input  data3,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

endinterface

// File: rtl/rr_arb_4ch_16bit_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Purely combinational rotating-priority picker for four requesters.
// Priority order is last+1, last+2, last+3, last (modulo 4), so the most
// recently granted channel always ranks lowest.
//   req[3:0]        : request vector
//   last            : most recently granted index
//   gnt_valid       : at least one request present
//   gnt_idx         : index of the winning requester (0 when none)
//   gnt_onehot[3:0] : one-hot form of gnt_idx, zero when no request
// ---------------------------------------------------------------------------
module rr_pick4
  import rr_arb_4ch_16bit_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       last,
  output logic       gnt_valid,
  output sel_t       gnt_idx,
  output logic [3:0] gnt_onehot
);

  sel_t cand;

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    cand       = '0;
    // Offset 4 wraps to 0 in sel_t, which puts 'last' itself at the end.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = rr_step(last, sel_t'(k));
      if (!gnt_valid && req[cand]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4ch_16bit.sv
// ---------------------------------------------------------------------------
// rr_arb_4ch_16bit
// Four-channel round-robin arbiter with a registered valid/ready output,
// feeding the 4:1 16-bit data select stage. One word is accepted per cycle
// from the channel chosen by rotating priority; the word and its channel
// index appear on out_data/out_sel one cycle later.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_arb_4ch_16bit_if.slave (channels in, registered output out)
// Combinational paths exist only from in_valid/out_ready to in_ready; all
// out_* signals come straight from flops.
// ---------------------------------------------------------------------------
module rr_arb_4ch_16bit
  import rr_arb_4ch_16bit_pkg::*;
#(
  parameter int WIDTH     = rr_arb_4ch_16bit_pkg::WIDTH,
  parameter int SEL_WIDTH = rr_arb_4ch_16bit_pkg::SEL_WIDTH
)
(
  input  logic                clk,
  input  logic                rst,
  rr_arb_4ch_16bit_if.slave   bus
);

  // Output register and arbitration state.
  out_state_t           state;
  logic                 vld_p1;
  logic [WIDTH-1:0]     data_p1;
  logic [SEL_WIDTH-1:0] sel_p1;
  sel_t                 last;

  // Arbitration (stage 0, combinational).
  logic                 load_en;
  logic                 gnt_valid;
  sel_t                 gnt_idx;
  logic [3:0]           gnt_onehot;
  logic [3:0]           ready_p0;
  logic                 xfer_p0;
  logic [WIDTH-1:0]     data_p0;

  rr_pick4 u_pick (
    .req        (bus.in_valid),
    .last       (last),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  // Stage 0: grant and payload select.
  // The register can take a word when it is empty or being drained now.
  assign load_en = !vld_p1 || bus.out_ready;

  // Reset suppresses ready so no source believes a word was taken while the
  // register is being cleared.
  assign ready_p0 = (!rst && load_en && gnt_valid) ? gnt_onehot : 4'b0000;
  assign xfer_p0  = |(ready_p0 & bus.in_valid);

  always_comb begin
    data_p0 = bus.data0;
    case (gnt_idx)
      2'd0:    data_p0 = bus.data0;
      2'd1:    data_p0 = bus.data1;
      2'd2:    data_p0 = bus.data2;
      default: data_p0 = bus.data3;
    endcase
  end

  // Stage 1: output register and occupancy FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= OUT_EMPTY;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      last    <= sel_t'(NUM_CH - 1);
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (xfer_p0) begin
            state  <= OUT_FULL;
            vld_p1 <= 1'b1;
          end
        end
        OUT_FULL: begin
          // Drain with a simultaneous load stays FULL with no bubble.
          if (bus.out_ready && !xfer_p0) begin
            state  <= OUT_EMPTY;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= OUT_EMPTY;
          vld_p1 <= 1'b0;
        end
      endcase
      // Payload, index and priority pointer move only on a transfer; a
      // drain to empty leaves the last word visible on out_data/out_sel.
      if (xfer_p0) begin
        data_p1 <= data_p0;
        sel_p1  <= gnt_idx;
        last    <= gnt_idx;
      end
    end
  end

  assign bus.in_ready  = ready_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_sel   = sel_p1;

endmodule
